// File: rtl/reduce_pkg.sv
// reduce_pkg: shared types and helpers for chunked_reduce_sequencer
//    mode_t   : condense operation (MODE_AND = 0, MODE_OR = 1)
//    state_t  : sequencer FSM states (IDLE, RUN, DONE)
//    identity : accumulator start value for a mode (AND -> 1, OR -> 0)
package reduce_pkg;
   typedef enum logic {MODE_AND = 1'b0, MODE_OR = 1'b1} mode_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic identity(input mode_t m);
      return m == MODE_AND;
   endfunction
endpackage

// File: rtl/chunk_reduce.sv
// chunk_reduce: combinational N-bit AND/OR reduction of one chunk
//    chunk : N-bit slice to reduce
//    mode  : MODE_AND -> &chunk, MODE_OR -> |chunk
//    red   : reduced bit
module chunk_reduce
   import reduce_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] chunk,
   input  mode_t        mode,
   output logic         red
);
   assign red = (mode == MODE_OR) ? |chunk : &chunk;
endmodule

// File: rtl/chunked_reduce_sequencer.sv
// chunked_reduce_sequencer: folds a W-bit vector to one bit, N bits per cycle
//    clk, rst_n           : clock, asynchronous active-low reset
//    in_valid/in_ready    : request handshake, in_vec/in_mode captured on accept
//    out_valid/out_ready  : result handshake
//    out_bit, out_chunks  : condensed bit and number of chunks examined
//    Define EARLY_EXIT_EN to stop on the first chunk that reduces to the
//    dominant value (0 for AND, 1 for OR).
module chunked_reduce_sequencer
   import reduce_pkg::*;
#(
   parameter int W = 256,
   parameter int N = 32,
   localparam int CHUNKS = W / N,
   localparam int CW = $clog2(CHUNKS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_vec,
   input  logic          in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic [CW-1:0] out_chunks
);
   state_t        state;
   mode_t         mode;
   logic [W-1:0]  vec;
   logic [CW-1:0] idx;
   logic          acc;
   logic [N-1:0]  chunk;
   logic          red;
   logic          nacc;
   logic          last;

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;

   // idx may legally reach CHUNKS, so select with a compare mux rather than a slice
   always_comb begin
      chunk = '0;
      for (int i = 0; i < CHUNKS; i++)
         if (idx == CW'(i)) chunk = vec[i*N +: N];
   end

   chunk_reduce #(.N(N)) u_red (.chunk(chunk), .mode(mode), .red(red));

   assign nacc = (mode == MODE_OR) ? (acc | red) : (acc & red);
   assign last = idx == CW'(CHUNKS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode       <= MODE_AND;
         vec        <= '0;
         idx        <= '0;
         acc        <= 1'b0;
         out_bit    <= 1'b0;
         out_chunks <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               vec   <= in_vec;
               mode  <= mode_t'(in_mode);
               acc   <= identity(mode_t'(in_mode));
               idx   <= '0;
               state <= RUN;
            end
            RUN: begin
               acc <= nacc;
               idx <= idx + CW'(1);
`ifdef EARLY_EXIT_EN
               // dominant value equals the mode bit: 0 for AND, 1 for OR
               if (red == mode) begin
                  out_bit    <= mode;
                  out_chunks <= idx + CW'(1);
                  state      <= DONE;
               end else if (last) begin
                  out_bit    <= nacc;
                  out_chunks <= CW'(CHUNKS);
                  state      <= DONE;
               end
`else
               if (last) begin
                  out_bit    <= nacc;
                  out_chunks <= CW'(CHUNKS);
                  state      <= DONE;
               end
`endif
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_chunked_reduce_sequencer.sv
// tb_chunked_reduce_sequencer: directed self-checking bench, W=256 N=32
module tb_chunked_reduce_sequencer;
   localparam int W = 256;
   localparam int N = 32;
   localparam int CW = 4;
`ifdef EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_vec = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_bit;
   logic [CW-1:0] out_chunks;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   chunked_reduce_sequencer #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_bit(out_bit), .out_chunks(out_chunks)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // present a request, accept it on the next edge, then wait for out_valid
   task automatic request(input logic [W-1:0] v, input logic m, output int lat);
      int a;
      in_valid = 1'b1;
      in_vec   = v;
      in_mode  = m;
      tick();
      in_valid = 1'b0;
      a = cyc;
      chk("in_ready_low_in_run", in_ready, 0);
      while (!out_valid && cyc - a < 20) tick();
      chk("valid_timeout", out_valid, 1);
      lat = cyc - a;
   endtask

   initial begin
      logic [W-1:0] v;
      int lat;
      int h;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_out_chunks", out_chunks, 0);
      rst_n = 1'b1;
      tick();

      // AND, all ones
      request({W{1'b1}}, 1'b0, lat);
      chk("and_ones_bit", out_bit, 1);
      chk("and_ones_chunks", out_chunks, 8);
      chk("and_ones_lat", lat, 8);
      tick();
      chk("and_ones_valid_1cyc", out_valid, 0);
      chk("and_ones_ready_back", in_ready, 1);

      // OR, only bit 255
      v = '0;
      v[255] = 1'b1;
      request(v, 1'b1, lat);
      chk("or_msb_bit", out_bit, 1);
      chk("or_msb_chunks", out_chunks, 8);
      chk("or_msb_lat", lat, 8);
      tick();

      // OR, all zeros
      request('0, 1'b1, lat);
      chk("or_zero_bit", out_bit, 0);
      chk("or_zero_chunks", out_chunks, 8);
      chk("or_zero_lat", lat, 8);
      tick();

      // AND, bit 40 (chunk 1) cleared
      v = {W{1'b1}};
      v[40] = 1'b0;
      request(v, 1'b0, lat);
      chk("and_b40_bit", out_bit, 0);
      chk("and_b40_chunks", out_chunks, EE ? 2 : 8);
      chk("and_b40_lat", lat, EE ? 2 : 8);
      tick();

      // backpressure: OR with bit 100 (chunk 3)
      out_ready = 1'b0;
      v = '0;
      v[100] = 1'b1;
      request(v, 1'b1, lat);
      chk("bp_lat", lat, EE ? 4 : 8);
      in_valid = 1'b1;
      in_vec   = '0;
      in_mode  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid_held", out_valid, 1);
         chk("bp_bit_held", out_bit, 1);
         chk("bp_chunks_held", out_chunks, EE ? 4 : 8);
         chk("bp_in_ready_low", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      tick();
      chk("bp_pulse_not_taken", in_ready, 1);

      // reset while RUN at idx=3
      in_valid = 1'b1;
      in_vec   = {W{1'b1}};
      in_mode  = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_bit", out_bit, 0);
      chk("post_rst_chunks", out_chunks, 0);
      h = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) h++;
         tick();
      end
      chk("post_rst_no_output", h, 0);

      // back-to-back with in_valid held; vector changes right after accept
      in_valid = 1'b1;
      in_vec   = {W{1'b1}};
      in_mode  = 1'b0;
      tick();
      h = cyc;
      v = {W{1'b1}};
      v[0] = 1'b0;
      in_vec = v;
      while (!out_valid && cyc - h < 20) tick();
      chk("b2b_first_valid", out_valid, 1);
      chk("b2b_first_lat", cyc - h, 8);
      chk("b2b_first_bit", out_bit, 1);
      chk("b2b_first_chunks", out_chunks, 8);
      tick();
      chk("b2b_idle_ready", in_ready, 1);
      tick();
      chk("b2b_second_accepted", in_ready, 0);
      in_valid = 1'b0;
      h = cyc;
      while (!out_valid && cyc - h < 20) tick();
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second_lat", cyc - h, EE ? 1 : 8);
      chk("b2b_second_bit", out_bit, 0);
      chk("b2b_second_chunks", out_chunks, EE ? 1 : 8);
      tick();
      chk("b2b_done_ready", in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/chunked_reduce_sequencer.md
# chunked_reduce_sequencer

Multi-cycle sequencer that condenses a wide bit vector to a single bit by feeding it through a narrow N-bit reduction stage one chunk per cycle, accumulating an AND or OR result. It sits in the Bloom filter query path: a lookup produces a wide hit vector, and this block folds it into one member/non-member bit without a W-wide reduction tree. Valid/ready handshakes sit on both sides, and the block processes one vector at a time.

## Interface
- W, 256: total input vector width; must be a multiple of N.
- N, 32: chunk width reduced per cycle.
- CHUNKS, W/N: derived, not overridden.
- CW, $clog2(CHUNKS+1): derived width of the chunk count.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_vec  in  W  vector to condense; chunk k = in_vec[k*N +: N].
- in_mode  in  1  0 = AND condense, 1 = OR condense.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_bit  out  1  condensed result.
- out_chunks  out  CW  number of chunks examined for this result.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On accept, register in_vec and in_mode, set acc to the identity (AND→1, OR→0) and idx = 0, then go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, acc ← acc op reduce_op(chunk[idx]) and idx ← idx+1.
  - When the chunk just processed is idx = CHUNKS-1, latch out_bit = new acc and out_chunks = CHUNKS, then go to DONE.
- DONE:
  - out_valid = 1; out_bit and out_chunks are held stable.
  - On out_ready, go to IDLE.
  - No request is accepted in the same cycle.
- Requests are processed in chunk order 0 → CHUNKS-1 (LSB chunk first).
- Input ports are ignored outside IDLE. The registered copy is used, so in_vec may change after accept.
- Reset values: state = IDLE, in_ready = 1 (derived from state), out_valid = 0, out_bit = 0, out_chunks = 0, acc = 0, idx = 0.
- Reset mid-operation (RUN or DONE): the request is discarded immediately and no output is produced.
- CHUNKS = 1: RUN lasts exactly one cycle.
- idx is CW bits wide and never wraps; it is cleared on every accept.

## Timing
- Accept at edge t; without early exit, out_valid rises at edge t+CHUNKS.
- out_valid stays high until the edge at which out_ready is sampled high. It is deasserted on the next edge and in_ready rises on that same edge.
- Minimum initiation interval is CHUNKS+2 cycles (accept, CHUNKS RUN cycles, a DONE cycle, an IDLE cycle). With out_ready held high, DONE lasts one cycle.
- All outputs are registered or derived directly from state; there is no combinational path from inputs to outputs.

## Configuration
- EARLY_EXIT_EN defined:
  - In RUN, if the current chunk reduces to the dominant value (AND mode: chunk reduces to 0; OR mode: chunk reduces to 1), go to DONE immediately.
  - In that case out_bit = dominant value and out_chunks = idx+1.
  - Latency becomes t+out_chunks.
- EARLY_EXIT_EN undefined:
  - Every request examines all CHUNKS chunks.
  - out_chunks is always CHUNKS and latency is fixed.

## Structure
- Package reduce_pkg holds:
  - the mode enum: MODE_AND = 0, MODE_OR = 1;
  - the state enum: IDLE, RUN, DONE;
  - a function identity(mode).
- Sub-module chunk_reduce (parameter N): purely combinational. It takes an N-bit chunk and mode and outputs &chunk or |chunk. It is instantiated once and driven by the registered vector sliced at idx.
- The top level contains the FSM, the vector/mode registers, idx, acc and the output registers.

## Test plan
All scenarios use W=256, N=32, CHUNKS=8.
- AND mode, in_vec all ones, out_ready=1 → out_bit=1, out_chunks=8, out_valid at accept+8 for exactly 1 cycle.
- OR mode, only bit 255 set → out_bit=1, out_chunks=8. OR mode, all zeros → out_bit=0, out_chunks=8.
- AND mode, all ones except bit 40 (chunk 1) → out_bit=0. With EARLY_EXIT_EN: out_chunks=2, valid at accept+2. Without it: out_chunks=8, valid at accept+8.
- Backpressure: out_ready low for 5 cycles after out_valid → out_valid, out_bit and out_chunks stable; in_ready=0; a new in_valid pulse during this time is not accepted.
- Back-to-back: in_valid held high with two different vectors → second accept occurs exactly 2 cycles after the first out_valid & out_ready handshake; results match the respective vectors.
- rst_n low during RUN at idx=3 → out_valid=0 throughout; after release in_ready=1, out_bit=0, out_chunks=0; the next request completes normally.
